// File: rtl/cam_result_unloader_if.sv
// cam_result_unloader_if
// Purpose: groups the result-array read port and the outgoing word stream
// of the CAM result unloader into one bundle.
// Signals:
//   input_mode       array access mode (RowxRow / ColxCol / 0 when idle)
//   addr_output_Row  row address toward the array
//   addr_output_Col  column address toward the array
//   Q_out_row        array row read data
//   Q_out_col        array column read data
//   out_valid        stream word valid
//   out_ready        downstream accept
//   out_data         captured word, zero-extended to OUT_WIDTH
//   out_index        row/column index of out_data
// Modports: master = unloader side, slave = array plus downstream consumer.
interface cam_result_unloader_if #(
    parameter int unsigned DATA_WIDTH     = 4,
    parameter int unsigned DATA_DEPTH     = 4,
    parameter int unsigned ADDR_WIDTH_CAM = 8,
    parameter int unsigned OUT_WIDTH      = 4
);
    logic [2:0]                input_mode;
    logic [ADDR_WIDTH_CAM-1:0] addr_output_Row;
    logic [ADDR_WIDTH_CAM-1:0] addr_output_Col;
    logic [DATA_WIDTH-1:0]     Q_out_row;
    logic [DATA_DEPTH-1:0]     Q_out_col;
    logic                      out_valid;
    logic                      out_ready;
    logic [OUT_WIDTH-1:0]      out_data;
    logic [ADDR_WIDTH_CAM-1:0] out_index;

    modport master (
        output input_mode,
        output addr_output_Row,
        output addr_output_Col,
        input  Q_out_row,
        input  Q_out_col,
        output out_valid,
        input  out_ready,
        output out_data,
        output out_index
    );

    modport slave (
        input  input_mode,
        input  addr_output_Row,
        input  addr_output_Col,
        output Q_out_row,
        output Q_out_col,
        input  out_valid,
        output out_ready,
        input  out_data,
        input  out_index
    );
endinterface

// File: rtl/cam_result_unloader.sv
// cam_result_unloader
// Purpose: read-side sequencer for the CAM result register array. On start
// it sweeps every row (row mode) or every column (column mode), holds each
// address for READ_LAT cycles to cover the array's registered read latency,
// and delivers each retrieved word on a valid/ready stream.
// Ports:
//   clk       clock, all logic on posedge
//   rst       synchronous active-high reset
//   start     begin a sweep (sampled only when idle)
//   col_mode  0 = row sweep, 1 = column sweep (sampled with start)
//   busy      high from the cycle after an accepted start until done
//   done      one-cycle pulse after the last word handshakes
//   bus       master side of cam_result_unloader_if (array port + stream)
module cam_result_unloader #(
    parameter int unsigned DATA_WIDTH     = 4,
    parameter int unsigned DATA_DEPTH     = 4,
    parameter int unsigned ADDR_WIDTH_CAM = 8,
    parameter int unsigned OUT_WIDTH      = 4,
    parameter int unsigned READ_LAT       = 2,
    parameter logic [2:0]  RowxRow        = 3'd1,
    parameter logic [2:0]  ColxCol        = 3'd2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  col_mode,
    output logic                  busy,
    output logic                  done,
    cam_result_unloader_if.master bus
);

    localparam int unsigned CNT_W = (READ_LAT < 1) ? 1 : $clog2(READ_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(READ_LAT);
    localparam logic [ADDR_WIDTH_CAM-1:0] LAST_ROW = ADDR_WIDTH_CAM'(DATA_DEPTH - 1);
    localparam logic [ADDR_WIDTH_CAM-1:0] LAST_COL = ADDR_WIDTH_CAM'(DATA_WIDTH - 1);
    localparam logic [2:0] MODE_NONE = 3'd0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                    state;
    logic                      col_sel;
    logic [ADDR_WIDTH_CAM-1:0] index;
    logic [CNT_W-1:0]          wait_cnt;
    logic [2:0]                mode_reg;
    logic [ADDR_WIDTH_CAM-1:0] addr_row_reg;
    logic [ADDR_WIDTH_CAM-1:0] addr_col_reg;
    logic                      valid_reg;
    logic [OUT_WIDTH-1:0]      data_reg;
    logic [ADDR_WIDTH_CAM-1:0] index_reg;

    logic                      handshake;
    logic                      slot_free;
    logic                      at_last;
    logic [ADDR_WIDTH_CAM-1:0] next_index;
    logic [OUT_WIDTH-1:0]      rd_word;

    // Stream handshake and whether the output register can take a new word.
    assign handshake  = valid_reg & bus.out_ready;
    assign slot_free  = ~valid_reg | bus.out_ready;
    assign next_index = index + 1'b1;
    assign at_last    = col_sel ? (index >= LAST_COL) : (index >= LAST_ROW);

    // Zero-extended array data for the active sweep direction.
    always_comb begin
        rd_word = OUT_WIDTH'(bus.Q_out_row);
        if (col_sel) begin
            rd_word = OUT_WIDTH'(bus.Q_out_col);
        end
    end

    // Sweep sequencer: state, address/mode drive, latency counter and output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            col_sel      <= 1'b0;
            index        <= '0;
            wait_cnt     <= '0;
            mode_reg     <= MODE_NONE;
            addr_row_reg <= '0;
            addr_col_reg <= '0;
            valid_reg    <= 1'b0;
            data_reg     <= '0;
            index_reg    <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;

            // A handshake empties the output register unless a capture below refills it.
            if (handshake) begin
                valid_reg <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        col_sel      <= col_mode;
                        index        <= '0;
                        wait_cnt     <= '0;
                        mode_reg     <= col_mode ? ColxCol : RowxRow;
                        addr_row_reg <= '0;
                        addr_col_reg <= '0;
                        busy         <= 1'b1;
                        state        <= READ;
                    end
                end

                READ: begin
                    if (wait_cnt != CNT_MAX) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end else if (slot_free) begin
                        // Array data for the held address is valid now; take it.
                        valid_reg <= 1'b1;
                        data_reg  <= rd_word;
                        index_reg <= index;
                        if (!at_last) begin
                            index        <= next_index;
                            wait_cnt     <= '0;
                            addr_row_reg <= col_sel ? '0 : next_index;
                            addr_col_reg <= col_sel ? next_index : '0;
                        end else begin
                            mode_reg     <= MODE_NONE;
                            addr_row_reg <= '0;
                            addr_col_reg <= '0;
                            state        <= DRAIN;
                        end
                    end
                    // Otherwise stall: address and counter hold, array data stays valid.
                end

                DRAIN: begin
                    if (handshake) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.input_mode      = mode_reg;
    assign bus.addr_output_Row = addr_row_reg;
    assign bus.addr_output_Col = addr_col_reg;
    assign bus.out_valid       = valid_reg;
    assign bus.out_data        = data_reg;
    assign bus.out_index       = index_reg;

endmodule

// File: tb/tb_cam_result_unloader.sv
// tb_cam_result_unloader
// Two unloader instances: A with the default geometry (4x4, READ_LAT=2) and
// B with an 8-column, 4-row array, READ_LAT=1 and an 8-bit stream. Each has a
// behavioural result array with registered read latency, a reference model
// that lists the expected words of a sweep from the array contents, and a
// monitor that pops and compares on every stream handshake.
module tb_cam_result_unloader;

    localparam int unsigned AW   = 8;
    localparam int unsigned A_DW = 4;
    localparam int unsigned A_DD = 4;
    localparam int unsigned A_OW = 4;
    localparam int unsigned A_RL = 2;
    localparam int unsigned B_DW = 8;
    localparam int unsigned B_DD = 4;
    localparam int unsigned B_OW = 8;
    localparam int unsigned B_RL = 1;

    typedef struct {
        logic [63:0] data;
        logic [63:0] idx;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int unsigned cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- instance A ----------------
    logic start_a = 1'b0;
    logic col_a   = 1'b0;
    logic busy_a;
    logic done_a;

    cam_result_unloader_if #(.DATA_WIDTH(A_DW), .DATA_DEPTH(A_DD),
                             .ADDR_WIDTH_CAM(AW), .OUT_WIDTH(A_OW)) bus_a ();

    cam_result_unloader #(.DATA_WIDTH(A_DW), .DATA_DEPTH(A_DD), .ADDR_WIDTH_CAM(AW),
                          .OUT_WIDTH(A_OW), .READ_LAT(A_RL),
                          .RowxRow(3'd1), .ColxCol(3'd2)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .col_mode(col_a),
        .busy(busy_a), .done(done_a), .bus(bus_a.master)
    );

    logic [A_DD*A_DW-1:0] mem_a = '0;
    logic [A_DW-1:0]      rp_a [A_RL];
    logic [A_DD-1:0]      cp_a [A_RL];

    function automatic logic [A_DW-1:0] row_word_a(input int k);
        return (k < int'(A_DD)) ? A_DW'(mem_a >> (k * int'(A_DW))) : '0;
    endfunction

    // Column k: bit i is element k of row i.
    function automatic logic [A_DD-1:0] col_word_a(input int k);
        logic [A_DD-1:0] w;
        w = '0;
        if (k < int'(A_DW)) begin
            for (int i = 0; i < int'(A_DD); i++) begin
                if (((row_word_a(i) >> k) & A_DW'(1)) != '0) w = w | (A_DD'(1) << i);
            end
        end
        return w;
    endfunction

    always @(posedge clk) begin
        rp_a[0] <= row_word_a(int'(bus_a.addr_output_Row));
        cp_a[0] <= col_word_a(int'(bus_a.addr_output_Col));
        for (int i = 1; i < int'(A_RL); i++) begin
            rp_a[i] <= rp_a[i-1];
            cp_a[i] <= cp_a[i-1];
        end
    end
    assign bus_a.Q_out_row = rp_a[A_RL-1];
    assign bus_a.Q_out_col = cp_a[A_RL-1];

    exp_t            q_a [$];
    int unsigned     hs_a [$];
    int unsigned     dn_a [$];
    logic            hold_a = 1'b0;
    logic [A_OW-1:0] hold_d_a;
    logic [AW-1:0]   hold_i_a;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            hold_a = 1'b0;
        end else begin
            if (hold_a) begin
                check("a_stall_valid", 64'(bus_a.out_valid), 64'(1));
                check("a_stall_data", 64'(bus_a.out_data), 64'(hold_d_a));
                check("a_stall_index", 64'(bus_a.out_index), 64'(hold_i_a));
            end
            hold_a   = bus_a.out_valid && !bus_a.out_ready;
            hold_d_a = bus_a.out_data;
            hold_i_a = bus_a.out_index;
            if (bus_a.out_valid && bus_a.out_ready) begin
                hs_a.push_back(cyc);
                if (q_a.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL a_word: got unexpected word 0x%0h index %0d, expected none (cycle %0d)",
                             bus_a.out_data, bus_a.out_index, cyc);
                end else begin
                    e = q_a.pop_front();
                    check("a_word_data", 64'(bus_a.out_data), e.data);
                    check("a_word_index", 64'(bus_a.out_index), e.idx);
                end
            end
            if (done_a) dn_a.push_back(cyc);
        end
    end

    task automatic issue_a(input logic col, output int unsigned s);
        exp_t e;
        int   n;
        n = col ? int'(A_DW) : int'(A_DD);
        for (int k = 0; k < n; k++) begin
            e.data = col ? 64'(col_word_a(k)) : 64'(row_word_a(k));
            e.idx  = 64'(k);
            q_a.push_back(e);
        end
        col_a   = col;
        start_a = 1'b1;
        s       = cyc;
        tick();
        start_a = 1'b0;
    endtask

    task automatic wait_done_a(input int max, input bit rnd);
        int t;
        t = 0;
        while (!done_a && t < max) begin
            if (rnd) bus_a.out_ready = ($urandom_range(0, 3) != 0);
            tick();
            t++;
        end
        check("a_done_seen", 64'(done_a), 64'(1));
        bus_a.out_ready = 1'b1;
        tick();
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, "_busy"}, 64'(busy_a), 64'(0));
        check({tag, "_done"}, 64'(done_a), 64'(0));
        check({tag, "_valid"}, 64'(bus_a.out_valid), 64'(0));
        check({tag, "_data"}, 64'(bus_a.out_data), 64'(0));
        check({tag, "_index"}, 64'(bus_a.out_index), 64'(0));
        check({tag, "_mode"}, 64'(bus_a.input_mode), 64'(0));
        check({tag, "_arow"}, 64'(bus_a.addr_output_Row), 64'(0));
        check({tag, "_acol"}, 64'(bus_a.addr_output_Col), 64'(0));
    endtask

    // Cycle-exact sweep timeline with out_ready held high; called at cycle s+1.
    task automatic timing_a(input logic col, input int unsigned s);
        int n, per, first, last_v;
        logic [63:0] m, act_addr, idle_addr;
        n      = col ? int'(A_DW) : int'(A_DD);
        per    = int'(A_RL) + 1;
        first  = int'(A_RL) + 2;
        last_v = first + per * (n - 1);
        m      = col ? 64'(2) : 64'(1);
        for (int c = 1; c <= last_v + 2; c++) begin
            act_addr  = (c <= last_v - 1) ? 64'((c - 1) / per) : 64'(0);
            idle_addr = col ? 64'(bus_a.addr_output_Row) : 64'(bus_a.addr_output_Col);
            check("a_t_valid", 64'(bus_a.out_valid),
                  64'(c >= first && c <= last_v && ((c - first) % per) == 0));
            check("a_t_done", 64'(done_a), 64'(c == last_v + 1));
            check("a_t_busy", 64'(busy_a), 64'(c >= 1 && c <= last_v));
            check("a_t_mode", 64'(bus_a.input_mode), (c <= last_v - 1) ? m : 64'(0));
            check("a_t_addr", col ? 64'(bus_a.addr_output_Col) : 64'(bus_a.addr_output_Row), act_addr);
            check("a_t_other_addr", idle_addr, 64'(0));
            check("a_t_cycle", 64'(cyc), 64'(s + 32'(c)));
            tick();
        end
    endtask

    // ---------------- instance B ----------------
    logic start_b = 1'b0;
    logic col_b   = 1'b0;
    logic busy_b;
    logic done_b;

    cam_result_unloader_if #(.DATA_WIDTH(B_DW), .DATA_DEPTH(B_DD),
                             .ADDR_WIDTH_CAM(AW), .OUT_WIDTH(B_OW)) bus_b ();

    cam_result_unloader #(.DATA_WIDTH(B_DW), .DATA_DEPTH(B_DD), .ADDR_WIDTH_CAM(AW),
                          .OUT_WIDTH(B_OW), .READ_LAT(B_RL),
                          .RowxRow(3'd1), .ColxCol(3'd2)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .col_mode(col_b),
        .busy(busy_b), .done(done_b), .bus(bus_b.master)
    );

    logic [B_DD*B_DW-1:0] mem_b = '0;
    logic [B_DW-1:0]      rp_b [B_RL];
    logic [B_DD-1:0]      cp_b [B_RL];

    function automatic logic [B_DW-1:0] row_word_b(input int k);
        return (k < int'(B_DD)) ? B_DW'(mem_b >> (k * int'(B_DW))) : '0;
    endfunction

    function automatic logic [B_DD-1:0] col_word_b(input int k);
        logic [B_DD-1:0] w;
        w = '0;
        if (k < int'(B_DW)) begin
            for (int i = 0; i < int'(B_DD); i++) begin
                if (((row_word_b(i) >> k) & B_DW'(1)) != '0) w = w | (B_DD'(1) << i);
            end
        end
        return w;
    endfunction

    always @(posedge clk) begin
        rp_b[0] <= row_word_b(int'(bus_b.addr_output_Row));
        cp_b[0] <= col_word_b(int'(bus_b.addr_output_Col));
        for (int i = 1; i < int'(B_RL); i++) begin
            rp_b[i] <= rp_b[i-1];
            cp_b[i] <= cp_b[i-1];
        end
    end
    assign bus_b.Q_out_row = rp_b[B_RL-1];
    assign bus_b.Q_out_col = cp_b[B_RL-1];

    exp_t            q_b [$];
    int unsigned     hs_b [$];
    int unsigned     dn_b [$];
    logic            hold_b = 1'b0;
    logic [B_OW-1:0] hold_d_b;
    logic [AW-1:0]   hold_i_b;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            hold_b = 1'b0;
        end else begin
            if (hold_b) begin
                check("b_stall_valid", 64'(bus_b.out_valid), 64'(1));
                check("b_stall_data", 64'(bus_b.out_data), 64'(hold_d_b));
                check("b_stall_index", 64'(bus_b.out_index), 64'(hold_i_b));
            end
            hold_b   = bus_b.out_valid && !bus_b.out_ready;
            hold_d_b = bus_b.out_data;
            hold_i_b = bus_b.out_index;
            if (bus_b.out_valid && bus_b.out_ready) begin
                hs_b.push_back(cyc);
                if (q_b.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL b_word: got unexpected word 0x%0h index %0d, expected none (cycle %0d)",
                             bus_b.out_data, bus_b.out_index, cyc);
                end else begin
                    e = q_b.pop_front();
                    check("b_word_data", 64'(bus_b.out_data), e.data);
                    check("b_word_index", 64'(bus_b.out_index), e.idx);
                end
            end
            if (done_b) dn_b.push_back(cyc);
        end
    end

    task automatic issue_b(input logic col, output int unsigned s);
        exp_t e;
        int   n;
        n = col ? int'(B_DW) : int'(B_DD);
        for (int k = 0; k < n; k++) begin
            e.data = col ? 64'(col_word_b(k)) : 64'(row_word_b(k));
            e.idx  = 64'(k);
            q_b.push_back(e);
        end
        col_b   = col;
        start_b = 1'b1;
        s       = cyc;
        tick();
        start_b = 1'b0;
    endtask

    task automatic wait_done_b(input int max, input bit rnd);
        int t;
        t = 0;
        while (!done_b && t < max) begin
            if (rnd) bus_b.out_ready = ($urandom_range(0, 3) != 0);
            tick();
            t++;
        end
        check("b_done_seen", 64'(done_b), 64'(1));
        bus_b.out_ready = 1'b1;
        tick();
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        int unsigned s;
        int          n_hs0, n_dn0;

        bus_a.out_ready = 1'b1;
        bus_b.out_ready = 1'b1;
        rst = 1'b1;
        repeat (3) tick();
        check_reset_a("a_rst");
        check("b_rst_busy", 64'(busy_b), 64'(0));
        check("b_rst_valid", 64'(bus_b.out_valid), 64'(0));
        check("b_rst_mode", 64'(bus_b.input_mode), 64'(0));
        rst = 1'b0;
        tick();

        // Row sweep over a one-hot diagonal: 1,2,4,8 at s+4/7/10/13, done at s+14.
        mem_a = {4'h8, 4'h4, 4'h2, 4'h1};
        issue_a(1'b0, s);
        timing_a(1'b0, s);

        // Column sweep of the same contents: words 1<<index, row address stays 0.
        issue_a(1'b1, s);
        timing_a(1'b1, s);

        // Backpressure: first word held for 10 cycles, address 1 held, nothing lost.
        bus_a.out_ready = 1'b0;
        issue_a(1'b0, s);
        repeat (3) tick();
        for (int c = 0; c < 10; c++) begin
            check("a_bp_valid", 64'(bus_a.out_valid), 64'(1));
            check("a_bp_data", 64'(bus_a.out_data), 64'(1));
            check("a_bp_arow", 64'(bus_a.addr_output_Row), 64'(1));
            tick();
        end
        bus_a.out_ready = 1'b1;
        wait_done_a(60, 1'b0);

        // Start and col_mode changes mid-sweep are ignored.
        n_hs0 = hs_a.size();
        n_dn0 = dn_a.size();
        issue_a(1'b0, s);
        repeat (3) tick();
        start_a = 1'b1;
        col_a   = 1'b1;
        tick();
        col_a = 1'b0;
        tick();
        col_a = 1'b1;
        tick();
        start_a = 1'b0;
        check("a_mid_mode", 64'(bus_a.input_mode), 64'(1));
        check("a_mid_acol", 64'(bus_a.addr_output_Col), 64'(0));
        wait_done_a(60, 1'b0);
        repeat (8) tick();
        check("a_mid_words", 64'(hs_a.size() - n_hs0), 64'(4));
        check("a_mid_dones", 64'(dn_a.size() - n_dn0), 64'(1));
        check("a_mid_idle", 64'(busy_a), 64'(0));
        col_a = 1'b0;

        // Reset during the second element's wait aborts with no done pulse.
        issue_a(1'b0, s);
        repeat (4) tick();
        n_dn0 = dn_a.size();
        rst = 1'b1;
        tick();
        check_reset_a("a_rst_mid");
        rst = 1'b0;
        q_a.delete();
        repeat (6) tick();
        check("a_rst_nodone", 64'(dn_a.size() - n_dn0), 64'(0));
        check("a_rst_idle_busy", 64'(busy_a), 64'(0));
        issue_a(1'b0, s);
        wait_done_a(60, 1'b0);
        check("a_rst_fresh_empty", 64'(q_a.size()), 64'(0));

        // Randomised contents, direction and backpressure.
        for (int r = 0; r < 8; r++) begin
            mem_a = 16'($urandom);
            issue_a(logic'($urandom_range(0, 1)), s);
            wait_done_a(300, 1'b1);
        end
        check("a_queue_empty", 64'(q_a.size()), 64'(0));

        // B: 8-column column sweep, READ_LAT=1 -> one word every 2 cycles.
        mem_b = {8'h81, 8'hF0, 8'h3C, 8'hA5};
        n_hs0 = hs_b.size();
        n_dn0 = dn_b.size();
        issue_b(1'b1, s);
        wait_done_b(100, 1'b0);
        check("b_col_words", 64'(hs_b.size() - n_hs0), 64'(B_DW));
        for (int k = 0; k < int'(B_DW) && (n_hs0 + k) < hs_b.size(); k++) begin
            check("b_col_cycle", 64'(hs_b[n_hs0 + k]), 64'(s + 3 + 32'(2 * k)));
        end
        if (dn_b.size() > n_dn0) check("b_done_cycle", 64'(dn_b[n_dn0]), 64'(s + 18));
        else check("b_done_cycle", 64'(0), 64'(s + 18));

        for (int r = 0; r < 6; r++) begin
            mem_b = $urandom;
            issue_b(logic'($urandom_range(0, 1)), s);
            wait_done_b(300, 1'b1);
        end
        check("b_queue_empty", 64'(q_b.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
